// File: rtl/data_mem_responder_pkg.sv
// Shared constants, state encoding and address helper for the data memory responder.
package data_mem_responder_pkg;

    localparam int WORD_W            = 32;
    localparam int DEFAULT_DEPTH     = 64;
    localparam int DEFAULT_LATENCY   = 4;
    localparam int DEFAULT_BASE_ADDR = 1024;
    localparam int CNT_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word index relative to the base byte address, in 32-bit unsigned arithmetic.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] diff;
        diff = addr - base;
        return diff >> 2;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage: DEPTH x WORD_W, cleared by reset, one synchronous write port
// and one combinational read port.
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Storage update: cleared on reset, otherwise written only when we is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the MEM stage. The pipeline freezes
// while ready is low (freeze = ~ready at the CPU top level).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       address,
    input  logic [WORD_W-1:0] write_data,
    output logic [WORD_W-1:0] read_data,
    output logic              ready,
    output logic              error
);

    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]    BASE_W  = 32'(BASE_ADDR);
    localparam logic [31:0]    DEPTH_W = 32'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WORD_W-1:0]  read_data_r;
    logic               error_r;
    logic               wr_pend_r;
    logic [AW-1:0]      wr_idx_r;
    logic [WORD_W-1:0]  wr_data_r;

    logic [31:0]        word_idx_s;
    logic               out_of_range_s;
    logic               req_s;
    logic               acc_err_s;
    logic               wr_ok_s;
    logic               rd_load_s;
    logic               finish_s;
    logic               we_s;
    logic               ready_s;
    logic [WORD_W-1:0]  arr_rdata_s;
    logic [WORD_W-1:0]  rd_value_s;

    // Address decode and request classification from the live (held) inputs.
    always_comb begin
        word_idx_s     = word_index(address, BASE_W);
        out_of_range_s = (address < BASE_W) || (word_idx_s >= DEPTH_W);
        req_s          = mem_read | mem_write;
        acc_err_s      = out_of_range_s | (mem_read & mem_write);
        wr_ok_s        = mem_write & ~out_of_range_s;
        rd_load_s      = mem_read & ~mem_write;
        rd_value_s     = out_of_range_s ? {WORD_W{1'b0}} : arr_rdata_s;
    end

    // Last ready-low cycle: the next edge enters DONE. With LATENCY=1 that is the
    // request cycle itself; otherwise it is the BUSY cycle where the counter hits zero.
    always_comb begin
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: finish_s = req_s && (LAT_M1 == {CNT_W{1'b0}});
            ST_BUSY: finish_s = req_s && (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1});
            ST_DONE: finish_s = 1'b0;
            default: finish_s = 1'b0;
        endcase
    end

    // Ready is combinational so an idle responder never stalls the pipeline.
    always_comb begin
        ready_s = 1'b1;
        case (state_r)
            ST_IDLE: ready_s = ~req_s;
            ST_BUSY: ready_s = 1'b0;
            ST_DONE: ready_s = 1'b1;
            default: ready_s = 1'b1;
        endcase
    end

    // Storage write happens on the edge that ends the DONE cycle.
    always_comb begin
        we_s = (state_r == ST_DONE) && wr_pend_r;
    end

    // FSM, latency counter, read_data register, error pulse and write capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            read_data_r <= {WORD_W{1'b0}};
            error_r     <= 1'b0;
            wr_pend_r   <= 1'b0;
            wr_idx_r    <= {AW{1'b0}};
            wr_data_r   <= {WORD_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        cnt_r   <= LAT_M1;
                        state_r <= (LAT_M1 == {CNT_W{1'b0}}) ? ST_DONE : ST_BUSY;
                    end else begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!req_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                    end else if (finish_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase

            if (finish_s) begin
                error_r   <= acc_err_s;
                wr_pend_r <= wr_ok_s;
                wr_idx_r  <= word_idx_s[AW-1:0];
                wr_data_r <= write_data;
                if (rd_load_s) begin
                    read_data_r <= rd_value_s;
                end
            end else begin
                error_r   <= 1'b0;
                wr_pend_r <= 1'b0;
            end
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (wr_idx_r),
        .wdata (wr_data_r),
        .raddr (word_idx_s[AW-1:0]),
        .rdata (arr_rdata_s)
    );

    assign read_data = read_data_r;
    assign ready     = ready_s;
    assign error     = error_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=4 and one LATENCY=1 instance
// share the request inputs; each step names which instance it checks.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;

    logic [31:0] rd4, rd1;
    logic        ready4, ready1, err4, err1;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .LATENCY(4), .BASE_ADDR(1024)) u4 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data),
        .read_data(rd4), .ready(ready4), .error(err4)
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(1), .BASE_ADDR(1024)) u1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data),
        .read_data(rd1), .ready(ready1), .error(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic sel_ready(input bit on1);
        return on1 ? ready1 : ready4;
    endfunction

    // Count ready-low negedges until ready is seen high (bounded).
    task automatic wait_done(input bit on1, output int low, output bit ok);
        low = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel_ready(on1) === 1'b1) begin
                ok = 1'b1;
                break;
            end else begin
                low++;
            end
        end
    endtask

    // One full access: drive, wait for DONE, check it, drop the request, check the idle cycle.
    task automatic xfer(input string tag, input bit on1, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int exp_low, input logic exp_err, input logic [31:0] exp_rdata);
        int low;
        bit ok;
        @(posedge clk);
        #1;
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = data;
        wait_done(on1, low, ok);
        chk({tag, "_done"}, 32'(ok), 32'd1);
        chk({tag, "_low"}, 32'(low), 32'(exp_low));
        chk({tag, "_err"}, 32'(on1 ? err1 : err4), 32'(exp_err));
        chk({tag, "_rdata"}, on1 ? rd1 : rd4, exp_rdata);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_ready"}, 32'(sel_ready(on1)), 32'd1);
        chk({tag, "_idle_err"}, 32'(on1 ? err1 : err4), 32'd0);
    endtask

    initial begin
        int  low;
        bit  ok;

        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready4", 32'(ready4), 32'd1);
        chk("rst_rdata4", rd4, 32'd0);
        chk("rst_err4", 32'(err4), 32'd0);
        chk("rst_ready1", 32'(ready1), 32'd1);
        rst = 1'b0;

        // Basic read / write / read-back
        xfer("rd1024_init", 1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 4, 1'b0, 32'h0000_0000);
        xfer("wr1028", 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4, 1'b0, 32'h0000_0000);
        xfer("rd1028", 1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 4, 1'b0, 32'hDEAD_BEEF);
        xfer("wr1024", 1'b0, 1'b0, 1'b1, 32'd1024, 32'h1111_1111, 4, 1'b0, 32'hDEAD_BEEF);
        xfer("wr1032", 1'b0, 1'b0, 1'b1, 32'd1032, 32'h3333_3333, 4, 1'b0, 32'hDEAD_BEEF);

        // Back-to-back reads: request held through DONE restarts a new access
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        address  = 32'd1024;
        wait_done(1'b0, low, ok);
        chk("b2b_a_done", 32'(ok), 32'd1);
        chk("b2b_a_low", 32'(low), 32'd4);
        chk("b2b_a_rdata", rd4, 32'h1111_1111);
        address = 32'd1032;
        wait_done(1'b0, low, ok);
        chk("b2b_b_done", 32'(ok), 32'd1);
        chk("b2b_b_low", 32'(low), 32'd4);
        chk("b2b_b_rdata", rd4, 32'h3333_3333);
        mem_read = 1'b0;
        @(negedge clk);
        chk("b2b_idle_ready", 32'(ready4), 32'd1);

        // Out-of-range accesses
        xfer("rd1020_oor", 1'b0, 1'b1, 1'b0, 32'd1020, 32'd0, 4, 1'b1, 32'h0000_0000);
        xfer("wr1280_oor", 1'b0, 1'b0, 1'b1, 32'd1280, 32'hBAD0_BAD0, 4, 1'b1, 32'h0000_0000);
        xfer("rd1276_last", 1'b0, 1'b1, 1'b0, 32'd1276, 32'd0, 4, 1'b0, 32'h0000_0000);
        xfer("rd1024_keep", 1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 4, 1'b0, 32'h1111_1111);

        // Read and write together: write only, read_data unchanged, error
        xfer("rw1040", 1'b0, 1'b1, 1'b1, 32'd1040, 32'h1234_5678, 4, 1'b1, 32'h1111_1111);
        xfer("rd1040", 1'b0, 1'b1, 1'b0, 32'd1040, 32'd0, 4, 1'b0, 32'h1234_5678);

        // Request dropped during BUSY: back to idle, no write, no error
        @(posedge clk);
        #1;
        mem_write  = 1'b1;
        address    = 32'd1044;
        write_data = 32'h55AA_55AA;
        @(negedge clk);
        chk("drop_idle_ready", 32'(ready4), 32'd0);
        @(negedge clk);
        chk("drop_busy_ready", 32'(ready4), 32'd0);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        chk("drop_busy2_err", 32'(err4), 32'd0);
        @(negedge clk);
        chk("drop_after_ready", 32'(ready4), 32'd1);
        chk("drop_after_err", 32'(err4), 32'd0);
        xfer("rd1044", 1'b0, 1'b1, 1'b0, 32'd1044, 32'd0, 4, 1'b0, 32'h0000_0000);

        // Reset in the second BUSY cycle of a write
        @(posedge clk);
        #1;
        mem_write  = 1'b1;
        address    = 32'd1048;
        write_data = 32'h7777_7777;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_rdata", rd4, 32'd0);
        chk("rst_mid_err", 32'(err4), 32'd0);
        mem_write = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(ready4), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        xfer("rd1048_after_rst", 1'b0, 1'b1, 1'b0, 32'd1048, 32'd0, 4, 1'b0, 32'h0000_0000);
        xfer("rd1028_after_rst", 1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 4, 1'b0, 32'h0000_0000);

        // LATENCY=1 instance: a single ready-low cycle per access
        xfer("l1_rd1024", 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 1, 1'b0, 32'h0000_0000);
        xfer("l1_wr1028", 1'b1, 1'b0, 1'b1, 32'd1028, 32'hCAFE_F00D, 1, 1'b0, 32'h0000_0000);
        xfer("l1_rd1028", 1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 1, 1'b0, 32'hCAFE_F00D);
        xfer("l1_rd1020_oor", 1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 1, 1'b1, 32'h0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
